mem_coalescer_arb: RTL
======================

Name: mem_coalescer_arb

Overview:
- Shares one memory coalescer between NUM_INPUTS SIMD requesters (e.g. LSU slices).
- Round-robin arbitration over whole requests; holds the grant until the request is accepted, because the coalescer may take several cycles per request.
- Registers the granted request and appends the source index to the low bits of the tag, so the UUID stays in the upper tag bits.
- Steers coalescer responses back to the owning requester by that index.

Parameters:
- NUM_INPUTS, 2, number of requesters (>=1; 1 degenerates to a register stage plus tag pass-through).
- NUM_REQS, 4, lanes per request.
- ADDR_WIDTH, 32, lane word-address width.
- ATYPE_WIDTH, 1, lane address-type width.
- DATA_SIZE, 4, lane data bytes.
- TAG_WIDTH, 8, requester tag width.
- SEL_W, LOG2UP(NUM_INPUTS), index bits appended to the tag.
- OUT_TAG_WIDTH, TAG_WIDTH+SEL_W, tag width toward the coalescer.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_req_valid  in  [NUM_INPUTS]  per-input request valid.
- in_req_rw  in  [NUM_INPUTS]  1=write.
- in_req_mask  in  [NUM_INPUTS][NUM_REQS]  lane mask.
- in_req_byteen  in  [NUM_INPUTS][NUM_REQS][DATA_SIZE]  byte enables.
- in_req_addr  in  [NUM_INPUTS][NUM_REQS][ADDR_WIDTH]  lane addresses.
- in_req_atype  in  [NUM_INPUTS][NUM_REQS][ATYPE_WIDTH]  lane address types.
- in_req_data  in  [NUM_INPUTS][NUM_REQS][DATA_SIZE*8]  write data.
- in_req_tag  in  [NUM_INPUTS][TAG_WIDTH]  tag.
- in_req_ready  out  [NUM_INPUTS]  per-input accept.
- in_rsp_valid  out  [NUM_INPUTS]  response valid.
- in_rsp_mask  out  [NUM_INPUTS][NUM_REQS]  response lane mask.
- in_rsp_data  out  [NUM_INPUTS][NUM_REQS][DATA_SIZE*8]  read data.
- in_rsp_tag  out  [NUM_INPUTS][TAG_WIDTH]  original tag.
- in_rsp_ready  in  [NUM_INPUTS]  response accept.
- out_req_valid, out_req_rw, out_req_mask, out_req_byteen, out_req_addr, out_req_atype, out_req_data  out  single-request widths as above  to coalescer.
- out_req_tag  out  OUT_TAG_WIDTH  {in_tag, sel}.
- out_req_ready  in  1  coalescer accept.
- out_rsp_valid, out_rsp_mask, out_rsp_data  in  single-response widths  from coalescer.
- out_rsp_tag  in  OUT_TAG_WIDTH  returned tag.
- out_rsp_ready  out  1  response accept.

Behaviour:
- Reset (synchronous): out_req_valid=0, rr_ptr=0, grant_lock=0. All other out_req_* fields are don't-care while out_req_valid=0.
- Request stage is a single register; its state is {out_req_valid, payload}.
  - stage_free = ~out_req_valid | out_req_ready.
- Arbitration when grant_lock=0:
  - sel = first valid input at or after rr_ptr, searching circularly.
- grant_lock/locked_sel:
  - Set when an input is selected but ~stage_free; the grant is then frozen.
  - Cleared when that request is loaded into the stage.
  - Requesters must hold valid and payload stable until ready.
- Acceptance:
  - in_req_ready[i] = stage_free & (i==sel) & any_valid.
  - On acceptance, the stage loads the selected payload with out_req_tag = {in_req_tag[sel], sel}, out_req_valid <= 1, and rr_ptr <= sel+1 (mod NUM_INPUTS).
  - If stage_free and no input is valid, out_req_valid <= 0.
- Throughput and latency:
  - One request per cycle under back-to-back out_req_ready.
  - Latency from in_req fire to out_req_valid is 1 cycle.
- Responses are combinational, 0 latency:
  - rsel = out_rsp_tag[SEL_W-1:0].
  - in_rsp_valid[i] = out_rsp_valid & (rsel==i).
  - in_rsp_tag[i] = out_rsp_tag[OUT_TAG_WIDTH-1:SEL_W]; mask and data are broadcast to all inputs.
  - out_rsp_ready = in_rsp_ready[rsel].
  - The request and response paths are independent; a request and a response may fire in the same cycle.
- rsel >= NUM_INPUTS is a runtime assertion failure.
- NUM_INPUTS==1: SEL_W=0, the tag passes through unchanged, and there is no arbitration logic.
- Reset mid-operation drops any registered request. Outstanding responses still route correctly, because routing is stateless.
- Write requests carry no response expectation; the arbiter tracks none.

Test Plan:
- Single request: NUM_INPUTS=2, input1 valid with tag 0x5A, ready=1 → next cycle out_req_valid=1, out_req_tag=0x0B5 ({0x5A,1}), in_req_ready[1] was 1 for one cycle.
- Fairness: both inputs continuously valid, out_req_ready=1 → grants alternate 0,1,0,1 for 8 cycles, one out_req per cycle.
- Backpressure lock: input0 granted into the stage, out_req_ready=0 for 5 cycles, input1 raised in cycle 2 → out_req payload stable; input1 granted only after the stage drains, and grant_lock holds sel while ~stage_free.
- Response steering: out_rsp_tag={0x33,1}, in_rsp_ready[1]=0 for 3 cycles → in_rsp_valid[1]=1, in_rsp_valid[0]=0, out_rsp_ready=0 until in_rsp_ready[1]=1; delivered in_rsp_tag=0x33.
- Concurrency: a request from input0 accepted in the same cycle a response for input1 fires → both complete with no stall.
- Reset mid-stream: assert reset while out_req_valid=1 → next cycle out_req_valid=0, rr_ptr=0, and the first post-reset grant goes to input0.

Source files
------------

// File: rtl/mem_coalescer_arb_if.sv
// Request/response bundle between NUM_INPUTS SIMD requesters, the shared
// coalescer arbiter and the coalescer itself.
interface mem_coalescer_arb_if #(
  parameter int NUM_INPUTS  = 2,
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int ATYPE_WIDTH = 1,
  parameter int DATA_SIZE   = 4,
  parameter int TAG_WIDTH   = 8
);
  localparam int SEL_W         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0;
  localparam int OUT_TAG_WIDTH = TAG_WIDTH + SEL_W;

  logic [NUM_INPUTS-1:0]                                in_req_valid;
  logic [NUM_INPUTS-1:0]                                in_req_rw;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0]                  in_req_mask;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][DATA_SIZE-1:0]   in_req_byteen;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][ADDR_WIDTH-1:0]  in_req_addr;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][ATYPE_WIDTH-1:0] in_req_atype;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][DATA_SIZE*8-1:0] in_req_data;
  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]                 in_req_tag;
  logic [NUM_INPUTS-1:0]                                in_req_ready;

  logic [NUM_INPUTS-1:0]                                in_rsp_valid;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0]                  in_rsp_mask;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][DATA_SIZE*8-1:0] in_rsp_data;
  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]                 in_rsp_tag;
  logic [NUM_INPUTS-1:0]                                in_rsp_ready;

  logic                                 out_req_valid;
  logic                                 out_req_rw;
  logic [NUM_REQS-1:0]                  out_req_mask;
  logic [NUM_REQS-1:0][DATA_SIZE-1:0]   out_req_byteen;
  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]  out_req_addr;
  logic [NUM_REQS-1:0][ATYPE_WIDTH-1:0] out_req_atype;
  logic [NUM_REQS-1:0][DATA_SIZE*8-1:0] out_req_data;
  logic [OUT_TAG_WIDTH-1:0]             out_req_tag;
  logic                                 out_req_ready;

  logic                                 out_rsp_valid;
  logic [NUM_REQS-1:0]                  out_rsp_mask;
  logic [NUM_REQS-1:0][DATA_SIZE*8-1:0] out_rsp_data;
  logic [OUT_TAG_WIDTH-1:0]             out_rsp_tag;
  logic                                 out_rsp_ready;

  modport slave (
    input  in_req_valid, in_req_rw, in_req_mask, in_req_byteen, in_req_addr,
           in_req_atype, in_req_data, in_req_tag, in_rsp_ready,
           out_req_ready, out_rsp_valid, out_rsp_mask, out_rsp_data, out_rsp_tag,
    output in_req_ready, in_rsp_valid, in_rsp_mask, in_rsp_data, in_rsp_tag,
           out_req_valid, out_req_rw, out_req_mask, out_req_byteen, out_req_addr,
           out_req_atype, out_req_data, out_req_tag, out_rsp_ready
  );

  modport master (
    output in_req_valid, in_req_rw, in_req_mask, in_req_byteen, in_req_addr,
           in_req_atype, in_req_data, in_req_tag, in_rsp_ready,
           out_req_ready, out_rsp_valid, out_rsp_mask, out_rsp_data, out_rsp_tag,
    input  in_req_ready, in_rsp_valid, in_rsp_mask, in_rsp_data, in_rsp_tag,
           out_req_valid, out_req_rw, out_req_mask, out_req_byteen, out_req_addr,
           out_req_atype, out_req_data, out_req_tag, out_rsp_ready
  );
endinterface

// File: rtl/mem_coalescer_arb.sv
// Round-robin arbiter sharing one memory coalescer between NUM_INPUTS requesters.
// Source index rides in the low tag bits and steers responses back statelessly.
module mem_coalescer_arb #(
  parameter int NUM_INPUTS  = 2,
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int ATYPE_WIDTH = 1,
  parameter int DATA_SIZE   = 4,
  parameter int TAG_WIDTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_coalescer_arb_if.slave io_bus
);
  localparam int SEL_W         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0;
  localparam int SEL_CW        = (SEL_W > 0) ? SEL_W : 1;
  localparam int OUT_TAG_WIDTH = TAG_WIDTH + SEL_W;

  typedef struct packed {
    logic                                 rw;
    logic [NUM_REQS-1:0]                  mask;
    logic [NUM_REQS-1:0][DATA_SIZE-1:0]   byteen;
    logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]  addr;
    logic [NUM_REQS-1:0][ATYPE_WIDTH-1:0] atype;
    logic [NUM_REQS-1:0][DATA_SIZE*8-1:0] data;
    logic [OUT_TAG_WIDTH-1:0]             tag;
  } req_t;

  logic               r_valid;
  req_t               r_req;
  req_t               w_req;
  logic               w_stage_free;
  logic               w_any;
  logic               w_fire;
  logic [SEL_CW-1:0]  w_sel;
  logic [OUT_TAG_WIDTH-1:0] w_tag;

  assign w_stage_free = ~r_valid | io_bus.out_req_ready;
  assign w_fire       = w_stage_free & w_any;

  always_comb begin
    w_req        = '0;
    w_req.rw     = io_bus.in_req_rw[w_sel];
    w_req.mask   = io_bus.in_req_mask[w_sel];
    w_req.byteen = io_bus.in_req_byteen[w_sel];
    w_req.addr   = io_bus.in_req_addr[w_sel];
    w_req.atype  = io_bus.in_req_atype[w_sel];
    w_req.data   = io_bus.in_req_data[w_sel];
    w_req.tag    = w_tag;
  end

  generate
    if (NUM_INPUTS > 1) begin : g_arb
      logic [SEL_CW-1:0]     r_rr_ptr;
      logic [SEL_CW-1:0]     r_lock_sel;
      logic                  r_lock;
      logic [SEL_CW-1:0]     w_rr_sel;
      logic [SEL_CW-1:0]     w_off;
      logic [SEL_CW:0]       w_sum;
      logic                  w_rr_any;
      logic [2*NUM_INPUTS-1:0] w_rot;
      logic [SEL_CW-1:0]     w_rsel;

      // Rotate the valid vector so bit 0 is the input at rr_ptr.
      assign w_rot = {io_bus.in_req_valid, io_bus.in_req_valid} >> r_rr_ptr;

      always_comb begin
        w_rr_any = 1'b0;
        w_off    = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
          if (w_rot[k]) begin
            w_rr_any = 1'b1;
            w_off    = SEL_CW'(k);
          end
        end
      end

      assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
      assign w_rr_sel = (w_sum >= (SEL_CW+1)'(NUM_INPUTS)) ?
                        SEL_CW'(w_sum - (SEL_CW+1)'(NUM_INPUTS)) : SEL_CW'(w_sum);

      // A grant that could not load is frozen until the stage drains.
      assign w_sel = r_lock ? r_lock_sel : w_rr_sel;
      assign w_any = r_lock ? io_bus.in_req_valid[r_lock_sel] : w_rr_any;
      assign w_tag = {io_bus.in_req_tag[w_sel], w_sel};

      always_ff @(posedge clk) begin
        if (reset) begin
          r_rr_ptr   <= '0;
          r_lock     <= 1'b0;
          r_lock_sel <= '0;
        end else begin
          r_lock     <= w_any & ~w_stage_free;
          r_lock_sel <= w_sel;
          if (w_fire)
            r_rr_ptr <= (w_sel == SEL_CW'(NUM_INPUTS - 1)) ? '0 : w_sel + 1'b1;
        end
      end

      always_comb begin
        io_bus.in_req_ready  = '0;
        io_bus.in_rsp_valid  = '0;
        io_bus.out_rsp_ready = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
          io_bus.in_req_ready[i] = w_fire & (w_sel == SEL_CW'(i));
          io_bus.in_rsp_valid[i] = io_bus.out_rsp_valid & (w_rsel == SEL_CW'(i));
          if (w_rsel == SEL_CW'(i))
            io_bus.out_rsp_ready = io_bus.in_rsp_ready[i];
        end
      end

      assign w_rsel            = io_bus.out_rsp_tag[SEL_W-1:0];
      assign io_bus.in_rsp_tag = {NUM_INPUTS{io_bus.out_rsp_tag[OUT_TAG_WIDTH-1:SEL_W]}};

      a_rsel_range: assert property (@(posedge clk) disable iff (reset)
        io_bus.out_rsp_valid |-> (int'(w_rsel) < NUM_INPUTS));
    end else begin : g_pass
      assign w_sel                = '0;
      assign w_any                = io_bus.in_req_valid[0];
      assign w_tag                = io_bus.in_req_tag[0];
      assign io_bus.in_req_ready  = w_fire;
      assign io_bus.in_rsp_valid  = io_bus.out_rsp_valid;
      assign io_bus.in_rsp_tag    = io_bus.out_rsp_tag;
      assign io_bus.out_rsp_ready = io_bus.in_rsp_ready[0];
    end
  endgenerate

  assign io_bus.in_rsp_mask = {NUM_INPUTS{io_bus.out_rsp_mask}};
  assign io_bus.in_rsp_data = {NUM_INPUTS{io_bus.out_rsp_data}};

  always_ff @(posedge clk) begin
    if (reset)             r_valid <= 1'b0;
    else if (w_stage_free) r_valid <= w_any;
  end

  // Payload is don't-care while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_fire) r_req <= w_req;
  end

  assign io_bus.out_req_valid  = r_valid;
  assign io_bus.out_req_rw     = r_req.rw;
  assign io_bus.out_req_mask   = r_req.mask;
  assign io_bus.out_req_byteen = r_req.byteen;
  assign io_bus.out_req_addr   = r_req.addr;
  assign io_bus.out_req_atype  = r_req.atype;
  assign io_bus.out_req_data   = r_req.data;
  assign io_bus.out_req_tag    = r_req.tag;
endmodule
